// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access.sv
// RV32I memory-access stage: load/store over a req/ack data-memory bus, single-entry result register.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of reaching memory.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_output,
  input  logic [XLEN-1:0]  store_data,
  input  logic [2:0]       funct3,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic [4:0]       rd,
  mem_access_if.master     dmem,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_alu_output,
  output logic [XLEN-1:0]  loaded_value,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic             misalign_trap
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t state, state_n;

  logic accept, is_mem, trap_hit, go_mem, direct, mem_done;

  // Captured memory request (held stable while the request is outstanding)
  logic [ADDR_W-1:0] addr_p0;
  logic              we_p0;
  logic [31:0]       wdata_p0;
  logic [3:0]        wstrb_p0;
  logic [1:0]        off_p0;
  logic [2:0]        f3_p0;
  logic [4:0]        rd_p0;
  logic              rw_p0;
  logic              load_p0;
  logic [XLEN-1:0]   alu_p0;

  // Write-back result register
  logic              vld_p1;
  logic [XLEN-1:0]   alu_p1;
  logic [XLEN-1:0]   ld_p1;
  logic [4:0]        rd_p1;
  logic              rw_p1;
  logic              m2r_p1;

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'b000:  return {4{sd[7:0]}};
      3'b001:  return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    bs = word[{off, 3'b000} +: 8];
    hs = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return 32'(bs);
      3'b100:  return {24'h0, bs};
      3'b001:  return 32'(hs);
      3'b101:  return {16'h0, hs};
      default: return word;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // Stores: 000 byte, 001 half, rest word. Loads: funct3[1:0] 00 byte, 01 half, rest word.
  function automatic logic misaligned(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic half, word;
    if (is_store) begin
      half = (f3 == 3'b001);
      word = (f3 != 3'b000) && (f3 != 3'b001);
    end else begin
      half = (f3[1:0] == 2'b01);
      word = f3[1];
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

  assign trap_hit = is_mem && misaligned(mem_write, funct3, alu_output[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  assign is_mem   = mem_read || mem_write;
  assign accept   = in_valid && in_ready;
  assign go_mem   = accept && is_mem && !trap_hit;
  assign direct   = accept && (!is_mem || trap_hit);
  assign mem_done = (state == MEM) && dmem.ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    dmem.req = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !vld_p1 || wb_ready;
        if (go_mem) state_n = MEM;
      end
      MEM: begin
        dmem.req = 1'b1;
        if (dmem.ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: capture the request on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_p0  <= '0;
      we_p0    <= 1'b0;
      wdata_p0 <= '0;
      wstrb_p0 <= '0;
      off_p0   <= '0;
      f3_p0    <= '0;
      rd_p0    <= '0;
      rw_p0    <= 1'b0;
      load_p0  <= 1'b0;
      alu_p0   <= '0;
    end else if (go_mem) begin
      addr_p0  <= {alu_output[ADDR_W-1:2], 2'b00};
      we_p0    <= mem_write;
      wdata_p0 <= mem_write ? store_lanes(funct3, store_data) : 32'h0;
      wstrb_p0 <= mem_write ? store_strb(funct3, alu_output[1:0]) : 4'b0000;
      off_p0   <= alu_output[1:0];
      f3_p0    <= funct3;
      rd_p0    <= rd;
      rw_p0    <= reg_write;
      load_p0  <= !mem_write;
      alu_p0   <= alu_output;
    end
  end

  assign dmem.addr  = addr_p0;
  assign dmem.we    = we_p0;
  assign dmem.wdata = wdata_p0;
  assign dmem.wstrb = wstrb_p0;

  // Stage p1: result register toward write_back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      alu_p1 <= '0;
      ld_p1  <= '0;
      rd_p1  <= '0;
      rw_p1  <= 1'b0;
      m2r_p1 <= 1'b0;
    end else if (direct) begin
      vld_p1 <= 1'b1;
      alu_p1 <= alu_output;
      ld_p1  <= '0;
      rd_p1  <= rd;
      rw_p1  <= reg_write && !trap_hit;
      m2r_p1 <= 1'b0;
    end else if (mem_done) begin
      vld_p1 <= 1'b1;
      alu_p1 <= alu_p0;
      ld_p1  <= load_p0 ? load_extend(f3_p0, off_p0, dmem.rdata) : 32'h0;
      rd_p1  <= rd_p0;
      rw_p1  <= rw_p0;
      m2r_p1 <= load_p0;
    end else if (wb_ready) begin
      vld_p1 <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic trap_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     trap_p1 <= 1'b0;
    else if (direct || mem_done)  trap_p1 <= trap_hit && direct;
    else if (wb_ready)            trap_p1 <= 1'b0;
  end

  assign misalign_trap = trap_p1;
`else
  assign misalign_trap = 1'b0;
`endif

  assign wb_valid      = vld_p1;
  assign wb_alu_output = alu_p1;
  assign loaded_value  = ld_p1;
  assign wb_rd         = rd_p1;
  assign wb_reg_write  = rw_p1;
  assign wb_mem_to_reg = m2r_p1;

endmodule
